vram_port_arbiter: RTL and testbench
====================================

// Module: vram_port_arbiter
// PURPOSE
//  Shares the single-port text VRAM of the HDMI text controller between two requesters.
//  - Video fetch (pixel/char renderer): deadline-critical.
//  - AXI4-Lite slave register/VRAM access path (bus).
//  Grants one access per cycle and drives the BRAM port; read data goes back to the requester that issued the read.
//  Bus starvation is bounded by a wait counter.
// PARAMETERS
//  ADDR_W    10  VRAM word address width
//  DATA_W    32  VRAM word width; multiple of 8
//  RD_LAT    2   BRAM read latency, cycles from mem_en to valid mem_rdata (1..4)
//  MAX_WAIT  8   consecutive denied bus cycles before bus is forced ahead of video (1..255)
// PORTS
//  clock       in   1         system clock; all logic on rising edge
//  reset       in   1         synchronous, active-high reset
//  vid_req     in   1         video read request; held until vid_gnt
//  vid_addr    in   ADDR_W    video read word address
//  vid_gnt     out  1         video request accepted this cycle
//  vid_rvalid  out  1         vid_rdata valid, 1-cycle pulse
//  vid_rdata   out  DATA_W    video read data, held between pulses
//  bus_req     in   1         bus request; held until bus_gnt
//  bus_we      in   1         1 = write, 0 = read
//  bus_addr    in   ADDR_W    bus word address
//  bus_wdata   in   DATA_W    bus write data
//  bus_wstrb   in   DATA_W/8  bus byte strobes (writes only)
//  bus_gnt     out  1         bus request accepted this cycle
//  bus_rvalid  out  1         bus_rdata valid, 1-cycle pulse (reads only)
//  bus_rdata   out  DATA_W    bus read data, held between pulses
//  mem_en      out  1         BRAM enable
//  mem_we      out  DATA_W/8  BRAM byte write enables
//  mem_addr    out  ADDR_W    BRAM address
//  mem_wdata   out  DATA_W    BRAM write data
//  mem_rdata   in   DATA_W    BRAM read data, RD_LAT cycles after mem_en
//  starve_evt  out  1         1-cycle pulse when the bus is forced ahead of a pending video request
// BEHAVIOUR
//  Reset:
//  - Every registered output is 0; wait_cnt = 0; tag pipeline all TAG_NONE.
//  - vid_gnt/bus_gnt are 0 while reset is high.
//  Arbitration (combinational, cycle t):
//  - vid_req only -> vid_gnt. bus_req only -> bus_gnt. Neither -> no grant.
//  - Both requesting, wait_cnt < MAX_WAIT -> vid_gnt.
//  - Both requesting, wait_cnt == MAX_WAIT -> bus_gnt, starve_evt = 1 (registered, seen at t+1).
//  - Never both grants in one cycle.
//  wait_cnt:
//  - +1 on each cycle with bus_req & !bus_gnt; saturates at MAX_WAIT.
//  - Cleared to 0 on bus_gnt or !bus_req.
//  Memory port (registered, cycle t+1 after grant at t):
//  - mem_en = 1; mem_addr = granted address.
//  - Bus write: mem_we = bus_wstrb, mem_wdata = bus_wdata.
//  - Reads: mem_we = 0.
//  - No grant at t: mem_en = 0, mem_we = 0; mem_addr/mem_wdata hold their last values.
//  - A bus write with wstrb = 0 still takes a grant and a slot; mem_we = 0.
//  Read return:
//  - Tag pipeline of depth 1+RD_LAT shifts every cycle; it carries TAG_VID, TAG_BUS (read), or TAG_NONE.
//  - The tag for grant at t exits at t+1+RD_LAT.
//  - At exit, mem_rdata is captured into vid_rdata or bus_rdata and the matching rvalid pulses at t+2+RD_LAT.
//  - Fixed latency grant->rvalid = RD_LAT+2; returns stay in grant order.
//  - Bus writes produce no rvalid.
//  Throughput: one access per cycle sustained; back-to-back reads give rvalid on consecutive cycles.
//  Reset mid-operation: the tag pipeline is flushed. Reads granted before or during reset never produce rvalid.
//  Read/write ordering: the BRAM is single-port, so a read granted after a write to the same address returns the new data.
//  No hazard logic is required.
// STRUCTURE
//  vram_arb_pkg (shared package):
//  - typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_BUS} vram_tag_t.
//  - Default-width localparams for ADDR_W and DATA_W, also used by the AXI slave and renderer.
//  Sub-module vram_tag_pipe (DEPTH = 1+RD_LAT):
//  - Shift register of vram_tag_t with synchronous flush.
//  - Output registers for rdata capture and rvalid.
//  Top level: arbitration, wait counter, mem port registers.
// TESTING
//  Model: behavioural BRAM with RD_LAT = 2; a scoreboard checks grant order against return order.
//  1. Reset held 3 cycles with both req high:
//     -> all outputs 0, no gnt; after release, first vid_gnt on the first cycle.
//  2. Bus write addr 0x010, data 0xDEADBEEF, wstrb 0xF, then a bus read of 0x010:
//     -> write: mem_en=1, mem_we=0xF at t+1.
//     -> read: bus_rvalid at gnt+4 with bus_rdata = 0xDEADBEEF.
//  3. vid_req and bus_req held high for 40 cycles, MAX_WAIT = 8:
//     -> 8 vid_gnt then 1 bus_gnt, repeating with period 9.
//     -> starve_evt pulses once per period.
//  4. Video reads of addr 0..15 on consecutive cycles:
//     -> vid_rvalid high 16 consecutive cycles starting gnt+4.
//     -> data in address order matches the model.
//  5. Bus read granted, reset asserted 1 cycle later for 1 cycle:
//     -> no bus_rvalid within 10 cycles; next bus read returns normally.
//  6. Write 0x11223344 (wstrb 0xF), then 0xAABBCCDD (wstrb 0x2), then read:
//     -> bus_rdata = 0x1122CC44.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared VRAM arbitration types and default widths, also used by the AXI slave and the renderer.
package vram_arb_pkg;

  localparam int VRAM_ADDR_W = 10;
  localparam int VRAM_DATA_W = 32;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_BUS  = 2'd2
  } vram_tag_t;

  // Owner of the read data that will come back for this cycle's grant.
  function automatic vram_tag_t grant_tag(input logic vid_gnt, input logic bus_rd_gnt);
    if (vid_gnt)    return TAG_VID;
    if (bus_rd_gnt) return TAG_BUS;
    return TAG_NONE;
  endfunction

endpackage

// File: rtl/vram_tag_pipe.sv
// Carries the owner tag of each VRAM access alongside the BRAM read latency and
// steers the returning read data to the video or bus requester.
module vram_tag_pipe
  import vram_arb_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  vram_tag_t         tag_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              bus_rvalid,
  output logic [DATA_W-1:0] bus_rdata
);

  vram_tag_t         tag_q [DEPTH];
  vram_tag_t         tag_d [DEPTH];
  logic              vid_rvalid_q, vid_rvalid_d;
  logic              bus_rvalid_q, bus_rvalid_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
  logic [DATA_W-1:0] bus_rdata_q, bus_rdata_d;

  // NOTE: every _d signal is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    tag_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    vid_rvalid_d = (tag_q[DEPTH-1] == TAG_VID);
    bus_rvalid_d = (tag_q[DEPTH-1] == TAG_BUS);
    vid_rdata_d  = vid_rvalid_d ? mem_rdata : vid_rdata_q;
    bus_rdata_d  = bus_rvalid_d ? mem_rdata : bus_rdata_q;
  end

  // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the tag array is control state and must flush on reset, unlike a plain data memory.
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= TAG_NONE;
      end
      vid_rvalid_q <= 1'b0;
      bus_rvalid_q <= 1'b0;
      vid_rdata_q  <= '0;
      bus_rdata_q  <= '0;
    end else begin
      tag_q        <= tag_d;
      vid_rvalid_q <= vid_rvalid_d;
      bus_rvalid_q <= bus_rvalid_d;
      vid_rdata_q  <= vid_rdata_d;
      bus_rdata_q  <= bus_rdata_d;
    end
  end

  assign vid_rvalid = vid_rvalid_q;
  assign bus_rvalid = bus_rvalid_q;
  assign vid_rdata  = vid_rdata_q;
  assign bus_rdata  = bus_rdata_q;

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares the single-port text VRAM between the video fetch path and the AXI4-Lite bus path;
// video wins ties unless the bus has waited MAX_WAIT cycles.
module vram_port_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W   = VRAM_ADDR_W,
  parameter int DATA_W   = VRAM_DATA_W,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                vid_req,
  input  logic [ADDR_W-1:0]   vid_addr,
  output logic                vid_gnt,
  output logic                vid_rvalid,
  output logic [DATA_W-1:0]   vid_rdata,
  input  logic                bus_req,
  input  logic                bus_we,
  input  logic [ADDR_W-1:0]   bus_addr,
  input  logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W/8-1:0] bus_wstrb,
  output logic                bus_gnt,
  output logic                bus_rvalid,
  output logic [DATA_W-1:0]   bus_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                starve_evt
);

  localparam int         STRB_W   = DATA_W / 8;
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              starve_evt_q, starve_evt_d;
  logic              mem_en_q, mem_en_d;
  logic [STRB_W-1:0] mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              force_bus;
  vram_tag_t         tag_in;

  always_comb begin
    // Bus has been denied long enough: it jumps ahead of a competing video request.
    force_bus = vid_req & bus_req & (wait_cnt_q == WAIT_MAX);
    vid_gnt   = ~reset & vid_req & ~force_bus;
    bus_gnt   = ~reset & bus_req & (~vid_req | force_bus);

    if (!bus_req || bus_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    starve_evt_d = force_bus & ~reset;
    mem_en_d     = vid_gnt | bus_gnt;
    mem_we_d     = (bus_gnt && bus_we) ? bus_wstrb : '0;
    mem_addr_d   = bus_gnt ? bus_addr : (vid_gnt ? vid_addr : mem_addr_q);
    mem_wdata_d  = (bus_gnt && bus_we) ? bus_wdata : mem_wdata_q;
    tag_in       = grant_tag(vid_gnt, bus_gnt & ~bus_we);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q   <= '0;
      starve_evt_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      starve_evt_q <= starve_evt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign starve_evt = starve_evt_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  // One stage for the mem port register, then RD_LAT stages of BRAM latency.
  vram_tag_pipe #(
    .DEPTH  (1 + RD_LAT),
    .DATA_W (DATA_W)
  ) u_tag_pipe (
    .clock      (clock),
    .reset      (reset),
    .tag_in     (tag_in),
    .mem_rdata  (mem_rdata),
    .vid_rvalid (vid_rvalid),
    .vid_rdata  (vid_rdata),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: behavioural BRAM, transaction-level reference
// model (shadow memory, return scoreboard), directed scenarios plus a randomized traffic phase.
module tb_vram_port_arbiter;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int STRB_W   = DATA_W / 8;
  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 8;
  localparam int WORDS    = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              vid_req, vid_gnt, vid_rvalid;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdata;
  logic              bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata, bus_rdata;
  logic [STRB_W-1:0] bus_wstrb;
  logic              mem_en;
  logic [STRB_W-1:0] mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              starve_evt;

  always #5 clock = ~clock;

  vram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clock(clock), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .starve_evt(starve_evt)
  );

  function automatic logic [DATA_W-1:0] init_word(input int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Behavioural single-port BRAM, read-first, RD_LAT cycles from mem_en to data.
  logic [DATA_W-1:0] bram    [WORDS];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clock) begin
    if (mem_en === 1'b1) begin
      rd_pipe[0] <= bram[mem_addr];
      for (int b = 0; b < STRB_W; b++)
        if (mem_we[b]) bram[mem_addr][b*8 +: 8] = mem_wdata[b*8 +: 8];
    end
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // Reference model state.
  typedef struct {
    int                due;
    bit                is_vid;
    logic [DATA_W-1:0] data;
  } ret_t;
  typedef struct {
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } bus_op_t;

  logic [DATA_W-1:0] shadow [WORDS];
  ret_t              sb [$];
  bus_op_t           bus_q [$];
  logic [ADDR_W-1:0] vid_q [$];

  int                cyc, wait_m;
  bit                regs_valid;
  logic              exp_mem_en, exp_starve, exp_wr;
  logic [STRB_W-1:0] exp_mem_we;
  logic [ADDR_W-1:0] exp_mem_addr;
  logic [DATA_W-1:0] exp_mem_wdata, exp_vid_rdata, exp_bus_rdata;
  logic              last_vg;
  int                n_checks, n_errors;
  int                obs_vid_gnt, obs_bus_gnt, obs_starve, obs_vid_rv, obs_bus_rv;
  int                vid_run, vid_run_max;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive requests from the queues, check mid-cycle, advance the model.
  task automatic cycle();
    logic    e_vg, e_bg, e_vr, e_br;
    ret_t    r;
    bus_op_t op;
    vid_req  = (vid_q.size() != 0);
    vid_addr = vid_req ? vid_q[0] : '0;
    if (bus_q.size() != 0) begin
      op = bus_q[0];
      bus_req = 1'b1; bus_we = op.we; bus_addr = op.addr; bus_wdata = op.wdata; bus_wstrb = op.wstrb;
    end else begin
      bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; bus_wstrb = '0;
    end
    @(negedge clock);

    e_vg = 1'b0; e_bg = 1'b0;
    if (!reset) begin
      if (vid_req && bus_req) begin
        if (wait_m >= MAX_WAIT) e_bg = 1'b1;
        else e_vg = 1'b1;
      end else begin
        e_vg = vid_req;
        e_bg = bus_req;
      end
    end
    check("vid_gnt", 64'(vid_gnt), 64'(e_vg));
    check("bus_gnt", 64'(bus_gnt), 64'(e_bg));
    last_vg = vid_gnt;
    obs_vid_gnt += int'(vid_gnt === 1'b1);
    obs_bus_gnt += int'(bus_gnt === 1'b1);

    if (regs_valid) begin
      e_vr = (sb.size() != 0) && (sb[0].due == cyc) && sb[0].is_vid;
      e_br = (sb.size() != 0) && (sb[0].due == cyc) && !sb[0].is_vid;
      if (e_vr || e_br) begin
        r = sb.pop_front();
        if (e_vr) exp_vid_rdata = r.data;
        else exp_bus_rdata = r.data;
      end
      check("vid_rvalid", 64'(vid_rvalid), 64'(e_vr));
      check("bus_rvalid", 64'(bus_rvalid), 64'(e_br));
      check("vid_rdata", 64'(vid_rdata), 64'(exp_vid_rdata));
      check("bus_rdata", 64'(bus_rdata), 64'(exp_bus_rdata));
      check("starve_evt", 64'(starve_evt), 64'(exp_starve));
      check("mem_en", 64'(mem_en), 64'(exp_mem_en));
      check("mem_we", 64'(mem_we), 64'(exp_mem_we));
      if (exp_mem_en) check("mem_addr", 64'(mem_addr), 64'(exp_mem_addr));
      if (exp_wr) check("mem_wdata", 64'(mem_wdata), 64'(exp_mem_wdata));
      obs_starve += int'(starve_evt === 1'b1);
      obs_vid_rv += int'(vid_rvalid === 1'b1);
      obs_bus_rv += int'(bus_rvalid === 1'b1);
      vid_run = (vid_rvalid === 1'b1) ? vid_run + 1 : 0;
      if (vid_run > vid_run_max) vid_run_max = vid_run;
    end

    exp_mem_en    = e_vg | e_bg;
    exp_wr        = e_bg && bus_we;
    exp_mem_we    = exp_wr ? bus_wstrb : '0;
    exp_mem_addr  = e_bg ? bus_addr : vid_addr;
    exp_mem_wdata = bus_wdata;
    exp_starve    = e_bg && vid_req;
    if (e_vg) begin
      r.due = cyc + RD_LAT + 2; r.is_vid = 1'b1; r.data = shadow[vid_addr];
      sb.push_back(r);
      void'(vid_q.pop_front());
    end
    if (e_bg) begin
      if (bus_we) begin
        for (int b = 0; b < STRB_W; b++)
          if (bus_wstrb[b]) shadow[bus_addr][b*8 +: 8] = bus_wdata[b*8 +: 8];
      end else begin
        r.due = cyc + RD_LAT + 2; r.is_vid = 1'b0; r.data = shadow[bus_addr];
        sb.push_back(r);
      end
      void'(bus_q.pop_front());
    end
    if (reset || !bus_req || e_bg) wait_m = 0;
    else if (wait_m < MAX_WAIT) wait_m++;
    if (reset) begin
      sb.delete();
      exp_vid_rdata = '0;
      exp_bus_rdata = '0;
    end

    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((vid_q.size() != 0 || bus_q.size() != 0 || sb.size() != 0) && n < limit) begin
      cycle();
      n++;
    end
    check("drain_left", 64'(vid_q.size() + bus_q.size() + sb.size()), 64'd0);
  endtask

  task automatic push_bus(input bit we, input int addr, input logic [DATA_W-1:0] wdata,
                          input logic [STRB_W-1:0] wstrb);
    bus_op_t op;
    op.we = we; op.addr = ADDR_W'(addr); op.wdata = wdata; op.wstrb = wstrb;
    bus_q.push_back(op);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, s0, v0, g0;
    n_checks = 0; n_errors = 0; cyc = 0; wait_m = 0; regs_valid = 0;
    exp_mem_en = 0; exp_starve = 0; exp_wr = 0; exp_mem_we = '0; exp_mem_addr = '0;
    exp_mem_wdata = '0; exp_vid_rdata = '0; exp_bus_rdata = '0; last_vg = 0;
    obs_vid_gnt = 0; obs_bus_gnt = 0; obs_starve = 0; obs_vid_rv = 0; obs_bus_rv = 0;
    vid_run = 0; vid_run_max = 0;
    for (int i = 0; i < WORDS; i++) begin
      bram[i]   = init_word(i);
      shadow[i] = init_word(i);
    end
    reset = 1'b1;
    vid_req = 0; vid_addr = '0; bus_req = 0; bus_we = 0; bus_addr = '0; bus_wdata = '0; bus_wstrb = '0;
    @(posedge clock);
    #1;
    regs_valid = 1;

    // 1. Reset held three cycles with both requesters active.
    vid_q.push_back(ADDR_W'(5));
    push_bus(1'b0, 6, '0, '0);
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    check("t1_first_vid_gnt", 64'(last_vg), 64'd1);
    drain(50);

    // 2. Bus write then read of the same word.
    cycle();
    push_bus(1'b1, 'h010, 32'hDEAD_BEEF, 4'hF);
    push_bus(1'b0, 'h010, '0, '0);
    drain(50);
    check("t2_bus_rdata", 64'(bus_rdata), 64'h0000_0000_DEAD_BEEF);

    // 3. Both requesters continuously busy for 40 cycles.
    cycle();
    for (int i = 0; i < 48; i++) begin
      vid_q.push_back(ADDR_W'($urandom_range(0, 63)));
      push_bus(1'b0, int'($urandom_range(0, 63)), '0, '0);
    end
    b0 = obs_bus_gnt; s0 = obs_starve; g0 = obs_vid_gnt;
    repeat (40) cycle();
    check("t3_bus_gnts", 64'(obs_bus_gnt - b0), 64'(40 / (MAX_WAIT + 1)));
    check("t3_vid_gnts", 64'(obs_vid_gnt - g0), 64'(40 - 40 / (MAX_WAIT + 1)));
    check("t3_starve_pulses", 64'(obs_starve - s0), 64'(40 / (MAX_WAIT + 1)));
    drain(200);

    // 4. Sixteen back-to-back video reads.
    cycle();
    v0 = obs_vid_rv; vid_run_max = 0;
    for (int a = 0; a < 16; a++) vid_q.push_back(ADDR_W'(a));
    drain(60);
    check("t4_vid_rvalid_count", 64'(obs_vid_rv - v0), 64'd16);
    check("t4_vid_rvalid_run", 64'(vid_run_max), 64'd16);

    // 5. Reset one cycle after a bus read grant cancels that read.
    cycle();
    push_bus(1'b0, 'h020, '0, '0);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    b0 = obs_bus_rv;
    repeat (10) cycle();
    check("t5_no_rvalid_after_reset", 64'(obs_bus_rv - b0), 64'd0);
    push_bus(1'b0, 'h020, '0, '0);
    drain(50);
    check("t5_read_after_reset", 64'(obs_bus_rv - b0), 64'd1);
    check("t5_rdata", 64'(bus_rdata), 64'(init_word('h020)));

    // 6. Partial-strobe write merges into the existing word.
    cycle();
    push_bus(1'b1, 'h030, 32'h1122_3344, 4'hF);
    push_bus(1'b1, 'h030, 32'hAABB_CCDD, 4'h2);
    push_bus(1'b0, 'h030, '0, '0);
    drain(50);
    check("t6_bus_rdata", 64'(bus_rdata), 64'h0000_0000_1122_CC44);

    // 7. Randomized mixed traffic over a small address window, including zero-strobe writes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 55 && vid_q.size() < 4)
        vid_q.push_back(ADDR_W'($urandom_range(0, 31)));
      if ($urandom_range(0, 99) < 45 && bus_q.size() < 3)
        push_bus(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom(),
                 STRB_W'($urandom_range(0, 15)));
      cycle();
    end
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
